pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register; next generation of the fixed-field stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a DATA_W payload and a CTRL_W control vector with a valid/ready handshake.
- A 2-entry skid buffer means in_ready is registered and comes from the stage's own state, so stalls do not ripple combinationally through the pipeline.
- Synchronous flush squashes in-flight entries to bubbles; control bits of a bubble are forced to zero so no write-enable fires downstream.

Parameters:
- DATA_W, 16, payload width (PC, result, read data packed by the instantiator).
- CTRL_W, 8, control-vector width (reg_write, mem_to_reg, JAL enable, halt, ...).
- RST_DATA, 0, payload value loaded into both entries on reset and flush.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous squash of all entries.
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  stage can accept; registered.
- in_data  input  DATA_W  upstream payload.
- in_ctrl  input  CTRL_W  upstream control vector.
- out_valid  output  1  main entry valid.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_W  main-entry payload.
- out_ctrl  output  CTRL_W  main-entry control; all zeros when out_valid=0.
- occupancy  output  2  entries held: 0, 1 or 2.

Behaviour:
- Handshake events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - in_valid may be asserted regardless of in_ready; data is held by the sender until in_fire.
- Storage: main entry (drives outputs) and skid entry, each holding {data, ctrl, valid}.
- FSM states: EMPTY, ONE (main valid), TWO (main and skid valid).
- in_ready = (state != TWO), registered. out_valid = main.valid.
- Transitions, evaluated only when flush=0:
  - EMPTY, in_fire: main <= in, go to ONE.
  - EMPTY, no in_fire: stay EMPTY.
  - ONE, in_fire and out_fire: main <= in, stay ONE.
  - ONE, in_fire and no out_fire: skid <= in, go to TWO.
  - ONE, out_fire only: main.valid <= 0, go to EMPTY.
  - ONE, neither: hold.
  - TWO, out_fire: main <= skid, skid.valid <= 0, go to ONE. in_ready is 0, so no capture that cycle.
  - TWO, no out_fire: hold all.
- Latency: an entry accepted in cycle N appears on out_* in cycle N+1 when the stage was EMPTY, or when it was ONE with out_fire in cycle N.
- Ordering: strict FIFO; the skid entry is never presented ahead of the main entry.
- Flush, highest priority:
  - Next state EMPTY; both valids cleared; data <= RST_DATA; ctrl <= 0.
  - in_valid is ignored and no in_fire is counted in that cycle, even though in_ready may read 1.
  - Flush together with out_fire: the presented entry is still consumed downstream that cycle.
- Reset (rst=0, asynchronous, any cycle including mid-transfer):
  - State EMPTY; data = RST_DATA; ctrl = 0; valids = 0.
  - out_valid = 0; in_ready = 1; occupancy = 0.
  - Release is synchronous to clk; the first capture is possible on the first rising edge after release.
- Bubble squash: out_ctrl = main.ctrl & {CTRL_W{out_valid}}. out_data is unmasked and holds its last value when invalid.
- Data stability: while out_valid=1 and out_ready=0, out_data and out_ctrl are held stable.
- occupancy = main.valid + skid.valid; it is never 2 while in_ready=1.

Optional Feature:
- Macro PIPE_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt [15:0], a counter of cycles with out_valid=1 and out_ready=0.
  - Saturates at 16'hFFFF; cleared by reset and by flush.
  - Readable for performance debug.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package pipe_pkg:
  - State enum pipe_state_t {EMPTY, ONE, TWO}.
  - Occupancy width constant.
  - Control-bit index constants shared by all stage instances: CTRL_REG_WRITE, CTRL_MEM_TO_REG, CTRL_JAL, CTRL_HALT, CTRL_BR_COND.
- Sub-module pipe_slot:
  - One entry: {data, ctrl, valid} register with load, clear and async active-low reset.
  - Instantiated twice (main, skid).
  - FSM and muxing stay in pipe_stage_reg.

Test Plan:
- Reset then stream: out_ready=1, in_valid=1, in_data=16'h0001..0x0005 on consecutive cycles -> out_data 1..5 one cycle later, no gaps; in_ready stays 1; occupancy=1.
- Backpressure: one entry held, out_ready=0, send 16'hAAAA -> occupancy=2 and in_ready=0 next cycle. Raise out_ready -> outputs appear in order (held entry, then AAAA); in_ready=1 one cycle after the first out_fire.
- Flush in TWO: flush=1 with in_valid=1, in_data=16'h5555 -> next cycle out_valid=0, occupancy=0, out_ctrl=0. 5555 never appears.
- Bubble squash: in_ctrl=8'hFF accepted, then out_fire with no new input -> out_valid=0 and out_ctrl=8'h00 while out_data retains its value.
- Async reset mid-transfer: rst=0 between clock edges while in TWO -> out_valid=0, in_ready=1, occupancy=0 immediately without a clock edge. After release, 16'h1234 is accepted on the first edge.
- PIPE_STALL_CNT_EN defined: out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF. Flush -> stall_cnt=0 next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared definitions for pipeline stage registers.
//   pipe_state_t : stage occupancy FSM states (EMPTY, ONE, TWO)
//   OCC_W        : width of the occupancy output
//   CTRL_*       : control-vector bit positions common to every stage
//   occ_count()  : number of valid entries held by a stage
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  localparam int OCC_W = 2;

  // Control-vector bit positions; every stage carries the same layout.
  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_TO_REG = 1;
  localparam int CTRL_JAL        = 2;
  localparam int CTRL_HALT       = 3;
  localparam int CTRL_BR_COND    = 4;

  function automatic logic [OCC_W-1:0] occ_count(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot -- one stage entry {data, ctrl, valid}.
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset (data=RST_DATA, ctrl=0, valid=0)
//   i_clear  synchronous squash, same result as reset
//   i_load   capture i_data/i_ctrl and mark the entry valid
//   i_drop   mark the entry invalid; data/ctrl keep their last value
//   i_data   payload to capture
//   i_ctrl   control vector to capture
//   o_data   stored payload
//   o_ctrl   stored control vector (unmasked)
//   o_valid  entry valid
// Priority: clear > load > drop.
module pipe_slot #(
  parameter int                DATA_W   = 16,
  parameter int                CTRL_W   = 8,
  parameter logic [DATA_W-1:0] RST_DATA = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic              i_drop,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic              o_valid
);

  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;
  logic              r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= RST_DATA;
      r_ctrl  <= '0;
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_data  <= RST_DATA;
      r_ctrl  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_ctrl  <= i_ctrl;
      r_valid <= 1'b1;
    end else if (i_drop) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_ctrl  = r_ctrl;
  assign o_valid = r_valid;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- parametrised pipeline stage register with a 2-entry
// skid buffer, so in_ready is registered and stalls never ripple
// combinationally upstream.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   flush      synchronous squash of both entries (highest priority)
//   in_valid   upstream entry valid
//   in_ready   stage can accept (registered)
//   in_data    upstream payload, DATA_W bits
//   in_ctrl    upstream control vector, CTRL_W bits
//   out_valid  main entry valid
//   out_ready  downstream accepts
//   out_data   main-entry payload (holds its value while invalid)
//   out_ctrl   main-entry control, forced to zero for a bubble
//   occupancy  number of entries held (0..2)
//   stall_cnt  only with PIPE_STALL_CNT_EN defined: saturating count of
//              cycles with out_valid=1 and out_ready=0, cleared by flush
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                CTRL_W   = 8,
  parameter logic [DATA_W-1:0] RST_DATA = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [OCC_W-1:0]  occupancy
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  pipe_state_t r_state;
  logic        r_in_ready;

  logic              w_in_fire;
  logic              w_out_fire;

  logic              w_main_load;
  logic              w_main_from_skid;
  logic              w_main_drop;
  logic              w_skid_load;
  logic              w_skid_drop;

  logic [DATA_W-1:0] w_main_d_data;
  logic [CTRL_W-1:0] w_main_d_ctrl;

  logic [DATA_W-1:0] w_main_data;
  logic [CTRL_W-1:0] w_main_ctrl;
  logic              w_main_valid;
  logic [DATA_W-1:0] w_skid_data;
  logic [CTRL_W-1:0] w_skid_ctrl;
  logic              w_skid_valid;

  // A flushing cycle never accepts, even if in_ready reads 1.
  assign w_in_fire  = in_valid & r_in_ready & ~flush;
  assign w_out_fire = w_main_valid & out_ready;

  // Slot load/drop strobes. Flush is handled by the slots' clear input.
  always_comb begin
    w_main_load      = 1'b0;
    w_main_from_skid = 1'b0;
    w_main_drop      = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_drop      = 1'b0;
    if (!flush) begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) w_main_load = 1'b1;
        end
        ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_main_load = 1'b1;
          end else if (w_in_fire) begin
            w_skid_load = 1'b1;
          end else if (w_out_fire) begin
            w_main_drop = 1'b1;
          end
        end
        TWO: begin
          // in_ready is 0 here, so only the skid-to-main move can happen.
          if (w_out_fire) begin
            w_main_load      = 1'b1;
            w_main_from_skid = 1'b1;
            w_skid_drop      = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_main_d_data = w_main_from_skid ? w_skid_data : in_data;
  assign w_main_d_ctrl = w_main_from_skid ? w_skid_ctrl : in_ctrl;

  // Occupancy FSM; in_ready is registered alongside the state so it
  // depends only on this stage's own occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
    end else if (flush) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) r_state <= ONE;
          r_in_ready <= 1'b1;
        end
        ONE: begin
          if (w_in_fire && !w_out_fire) begin
            r_state    <= TWO;
            r_in_ready <= 1'b0;
          end else if (w_out_fire && !w_in_fire) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
          end
        end
        TWO: begin
          if (w_out_fire) begin
            r_state    <= ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= EMPTY;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  pipe_slot #(
    .DATA_W   (DATA_W),
    .CTRL_W   (CTRL_W),
    .RST_DATA (RST_DATA)
  ) u_main (
    .clk     (clk),
    .rst_n   (rst),
    .i_clear (flush),
    .i_load  (w_main_load),
    .i_drop  (w_main_drop),
    .i_data  (w_main_d_data),
    .i_ctrl  (w_main_d_ctrl),
    .o_data  (w_main_data),
    .o_ctrl  (w_main_ctrl),
    .o_valid (w_main_valid)
  );

  pipe_slot #(
    .DATA_W   (DATA_W),
    .CTRL_W   (CTRL_W),
    .RST_DATA (RST_DATA)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst),
    .i_clear (flush),
    .i_load  (w_skid_load),
    .i_drop  (w_skid_drop),
    .i_data  (in_data),
    .i_ctrl  (in_ctrl),
    .o_data  (w_skid_data),
    .o_ctrl  (w_skid_ctrl),
    .o_valid (w_skid_valid)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = w_main_valid;
  assign out_data  = w_main_data;
  // A bubble must never carry a live write-enable downstream.
  assign out_ctrl  = w_main_ctrl & {CTRL_W{w_main_valid}};
  assign occupancy = occ_count(w_main_valid, w_skid_valid);

`ifdef PIPE_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (flush) begin
      r_stall_cnt <= '0;
    end else if (w_main_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg -- self-checking bench for pipe_stage_reg.
// Reference model: an ordered queue of at most two entries, plus the
// last presented payload and (with PIPE_STALL_CNT_EN) a stall count.
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [7:0]  in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [7:0]  out_ctrl;
  logic [1:0]  occupancy;
`ifdef PIPE_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  pipe_stage_reg #(
    .DATA_W   (16),
    .CTRL_W   (8),
    .RST_DATA (16'h0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
`ifdef PIPE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [7:0]  c;
  } ent_t;

  ent_t        m_q[$];
  logic [15:0] m_last_data;
  int          m_stall;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_last_data = 16'h0000;
    m_stall     = 0;
  endtask

  task automatic check_outputs(input string tag);
    int n;
    n = m_q.size();
    check({tag, ".out_valid"}, {31'd0, out_valid}, (n > 0) ? 32'd1 : 32'd0);
    check({tag, ".in_ready"},  {31'd0, in_ready},  (n < 2) ? 32'd1 : 32'd0);
    check({tag, ".occupancy"}, {30'd0, occupancy}, n);
    check({tag, ".out_data"},  {16'd0, out_data},  (n > 0) ? {16'd0, m_q[0].d} : {16'd0, m_last_data});
    check({tag, ".out_ctrl"},  {24'd0, out_ctrl},  (n > 0) ? {24'd0, m_q[0].c} : 32'd0);
`ifdef PIPE_STALL_CNT_EN
    check({tag, ".stall_cnt"}, {16'd0, stall_cnt}, m_stall);
`endif
  endtask

  // One clock cycle: drive inputs, advance the model using its pre-edge
  // view, then compare just after the edge.
  task automatic step(input string tag, input logic iv, input logic [15:0] d,
                      input logic [7:0] c, input logic ordy, input logic fl);
    bit   in_f, out_f;
    ent_t e;
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    in_f  = iv && (m_q.size() < 2) && !fl;
    out_f = (m_q.size() > 0) && ordy;
    if (fl) m_stall = 0;
    else if ((m_q.size() > 0) && !ordy && (m_stall < 65535)) m_stall++;
    @(posedge clk);
    if (fl) begin
      m_q.delete();
      m_last_data = 16'h0000;
    end else begin
      if (out_f) void'(m_q.pop_front());
      if (in_f) begin
        e.d = d;
        e.c = c;
        m_q.push_back(e);
      end
    end
    if (m_q.size() > 0) m_last_data = m_q[0].d;
    #1;
    check_outputs(tag);
  endtask

  initial begin
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0;
    in_ctrl   = 8'h0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_outputs("reset");
    $display("phase reset done");

    // Stream: each word appears one cycle after acceptance with no gaps.
    for (int i = 1; i <= 5; i++) begin
      step("stream", 1'b1, 16'(i), 8'h03, 1'b1, 1'b0);
      check("stream.data_const", {16'd0, out_data}, i);
      check("stream.occ_const", {30'd0, occupancy}, 32'd1);
    end
    step("stream_drain", 1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
    $display("phase stream done");

    // Backpressure into the skid entry, then ordered drain.
    step("bp_hold", 1'b1, 16'h0007, 8'h11, 1'b0, 1'b0);
    step("bp_fill", 1'b1, 16'hAAAA, 8'h22, 1'b0, 1'b0);
    check("bp.occ_two", {30'd0, occupancy}, 32'd2);
    check("bp.ready_low", {31'd0, in_ready}, 32'd0);
    step("bp_pop1", 1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
    check("bp.second_out", {16'd0, out_data}, 32'h0000AAAA);
    check("bp.ready_back", {31'd0, in_ready}, 32'd1);
    step("bp_pop2", 1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
    $display("phase backpressure done");

    // Flush while full, with a competing input that must be dropped.
    step("fl_fill1", 1'b1, 16'h1111, 8'h0F, 1'b0, 1'b0);
    step("fl_fill2", 1'b1, 16'h2222, 8'hF0, 1'b0, 1'b0);
    step("flush", 1'b1, 16'h5555, 8'hFF, 1'b0, 1'b1);
    check("flush.valid", {31'd0, out_valid}, 32'd0);
    check("flush.ctrl", {24'd0, out_ctrl}, 32'd0);
    step("fl_after", 1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
    $display("phase flush done");

    // Bubble squash: control masked, data retained.
    step("bub_load", 1'b1, 16'hBEEF, 8'hFF, 1'b0, 1'b0);
    step("bub_pop", 1'b0, 16'h0, 8'h0, 1'b1, 1'b0);
    check("bubble.ctrl", {24'd0, out_ctrl}, 32'd0);
    check("bubble.data", {16'd0, out_data}, 32'h0000BEEF);
    $display("phase bubble done");

    // Asynchronous reset in the middle of a cycle while full.
    step("ar_fill1", 1'b1, 16'h3333, 8'h01, 1'b0, 1'b0);
    step("ar_fill2", 1'b1, 16'h4444, 8'h02, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("arst.valid", {31'd0, out_valid}, 32'd0);
    check("arst.ready", {31'd0, in_ready}, 32'd1);
    check("arst.occ", {30'd0, occupancy}, 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step("arst_first", 1'b1, 16'h1234, 8'h05, 1'b1, 1'b0);
    check("arst.first_data", {16'd0, out_data}, 32'h00001234);
    $display("phase async reset done");

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step("rand", ($urandom % 4) != 0, 16'($urandom), 8'($urandom),
           ($urandom % 3) != 0 ? 1'b1 : 1'b0, ($urandom % 40) == 0);
    end
    $display("phase random done");

`ifdef PIPE_STALL_CNT_EN
    step("st_flush", 1'b0, 16'h0, 8'h0, 1'b0, 1'b1);
    step("st_load", 1'b1, 16'h4242, 8'h5A, 1'b0, 1'b0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (70000) @(posedge clk);
    m_stall = (m_stall + 70000 > 65535) ? 65535 : m_stall + 70000;
    #1;
    check("stall.sat", {16'd0, stall_cnt}, 32'h0000FFFF);
    check_outputs("stall_hold");
    step("st_clear", 1'b0, 16'h0, 8'h0, 1'b0, 1'b1);
    check("stall.clear", {16'd0, stall_cnt}, 32'd0);
    $display("phase stall counter done");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
